// File: rtl/line_buf_pkg.sv
// Shared definitions for the SDP-RAM line-buffer controller: FSM state
// encoding and the default geometry used by the controller and its wrapper.
package line_buf_pkg;

   // Frame position of the controller
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LINE0 = 2'd1,
      ST_LINEN = 2'd2
   } line_state_e;

   localparam int DEF_ADDR_WIDTH = 11;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LINE_LEN   = 1280;
   localparam int DEF_LINE_CNT_W = 12;

endpackage : line_buf_pkg

// File: rtl/sdpram_line_buf_ctrl.sv
// Line-buffer sequencer for a simple dual-port RAM used as a one-line delay.
// Each accepted pixel reads the previous line's pixel at its column in the
// accept cycle and overwrites that location one cycle later, so the current
// and previous-line pixels leave the block aligned, one cycle after accept.
module sdpram_line_buf_ctrl
   import line_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LINE_LEN   = DEF_LINE_LEN,
   parameter int LINE_CNT_W = DEF_LINE_CNT_W
)(
   input  logic                  wr_clk,
   input  logic                  tb_wr_rst,
   input  logic                  sof,
   input  logic                  pix_vld,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_cur,
   output logic [DATA_WIDTH-1:0] out_prev,
   output logic [ADDR_WIDTH-1:0] out_col,
   output logic [LINE_CNT_W-1:0] out_line,
   output logic                  line_done
);

   // Line length must leave at least two columns (no same-address
   // read/write collision) and must fit the RAM address range.
   if ((LINE_LEN < 2) || (LINE_LEN > (1 << ADDR_WIDTH))) begin : g_bad_line_len
      $fatal(1, "sdpram_line_buf_ctrl: LINE_LEN out of range 2..2**ADDR_WIDTH");
   end

   localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_LEN - 1);

   // Saturating increment for the line counter
   function automatic logic [LINE_CNT_W-1:0] sat_inc(input logic [LINE_CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(LINE_CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   line_state_e           state_r, state_nxt_s, eff_state_s;
   logic [ADDR_WIDTH-1:0] col_r, col_nxt_s, eff_col_s;
   logic [LINE_CNT_W-1:0] line_r, line_nxt_s, eff_line_s;
   logic                  sof_s, accept_s, wrap_s;

   logic                  vld_r;
   logic [ADDR_WIDTH-1:0] col_out_r;
   logic [DATA_WIDTH-1:0] pix_r;
   logic [LINE_CNT_W-1:0] line_out_r;
   logic                  done_r;
   logic                  prev_sel_r;

   // Effective position of the incoming pixel: sof restarts at col 0, line 0
   always_comb begin
      sof_s       = sof & pix_vld;
      accept_s    = 1'b0;
      eff_col_s   = col_r;
      eff_line_s  = line_r;
      eff_state_s = state_r;
      if (sof_s) begin
         accept_s    = 1'b1;
         eff_col_s   = {ADDR_WIDTH{1'b0}};
         eff_line_s  = {LINE_CNT_W{1'b0}};
         eff_state_s = ST_LINE0;
      end else begin
         accept_s    = pix_vld & (state_r != ST_IDLE);
      end
      wrap_s = (eff_col_s == LAST_COL);
   end

   // Next state, column and line counters
   always_comb begin
      state_nxt_s = state_r;
      col_nxt_s   = col_r;
      line_nxt_s  = line_r;
      if (accept_s) begin
         if (wrap_s) begin
            col_nxt_s  = {ADDR_WIDTH{1'b0}};
            line_nxt_s = sat_inc(eff_line_s);
         end else begin
            col_nxt_s  = eff_col_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            line_nxt_s = eff_line_s;
         end
         case (eff_state_s)
            ST_LINE0: state_nxt_s = wrap_s ? ST_LINEN : ST_LINE0;
            ST_LINEN: state_nxt_s = ST_LINEN;
            default:  state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
         col_nxt_s   = col_r;
         line_nxt_s  = line_r;
      end
   end

   // FSM and position counters
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         state_r <= ST_IDLE;
         col_r   <= {ADDR_WIDTH{1'b0}};
         line_r  <= {LINE_CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         col_r   <= col_nxt_s;
         line_r  <= line_nxt_s;
      end
   end

   // Write/output stage: data and position of the pixel accepted last cycle
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         vld_r      <= 1'b0;
         col_out_r  <= {ADDR_WIDTH{1'b0}};
         pix_r      <= {DATA_WIDTH{1'b0}};
         line_out_r <= {LINE_CNT_W{1'b0}};
         done_r     <= 1'b0;
         prev_sel_r <= 1'b0;
      end else if (accept_s) begin
         vld_r      <= 1'b1;
         col_out_r  <= eff_col_s;
         pix_r      <= pix_data;
         line_out_r <= eff_line_s;
         done_r     <= wrap_s;
         prev_sel_r <= (eff_state_s == ST_LINEN);
      end else begin
         vld_r      <= 1'b0;
         done_r     <= 1'b0;
         prev_sel_r <= 1'b0;
      end
   end

   // Read address follows the accept-cycle column; RAM returns data next cycle
   assign ram_rd_addr = eff_col_s;

   assign ram_wr_en   = vld_r;
   assign ram_wr_addr = col_out_r;
   assign ram_wr_data = pix_r;

   assign out_vld     = vld_r;
   assign out_cur     = pix_r;
   assign out_col     = col_out_r;
   assign out_line    = line_out_r;
   assign line_done   = done_r;
   // Line 0 has no valid previous line; mask whatever the RAM holds
   assign out_prev    = prev_sel_r ? ram_rd_data : {DATA_WIDTH{1'b0}};

endmodule : sdpram_line_buf_ctrl

// File: tb/tb_sdpram_line_buf_ctrl.sv
// Scoreboard bench for sdpram_line_buf_ctrl with LINE_LEN = 4 and a
// behavioural 2048x8 RAM (synchronous read, latency 1).
module tb_sdpram_line_buf_ctrl;
   import line_buf_pkg::*;

   localparam int AW = 11;
   localparam int DW = 8;
   localparam int LW = 12;

   typedef struct {
      logic [DW-1:0] cur;
      logic [DW-1:0] prev;
      logic [AW-1:0] col;
      logic [LW-1:0] line;
      logic          done;
   } exp_t;

   logic          wr_clk = 1'b0;
   logic          tb_wr_rst;
   logic          sof, pix_vld;
   logic [DW-1:0] pix_data;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr, out_col;
   logic [DW-1:0] ram_wr_data, ram_rd_data, out_cur, out_prev;
   logic          out_vld, line_done;
   logic [LW-1:0] out_line;

   logic [DW-1:0] mem [0:2047];
   exp_t          exp_q[$];
   int            total = 0;
   int            bad   = 0;

   sdpram_line_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_LEN(4), .LINE_CNT_W(LW)) dut (
      .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .sof(sof), .pix_vld(pix_vld), .pix_data(pix_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .out_vld(out_vld), .out_cur(out_cur), .out_prev(out_prev), .out_col(out_col),
      .out_line(out_line), .line_done(line_done)
   );

   always #5 wr_clk = ~wr_clk;

   // Behavioural RAM: read returns the pre-write contents of the addressed word
   always @(posedge wr_clk) begin
      ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: every presented output pair must match the next expected entry
   always @(negedge wr_clk) begin
      if (out_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_vld", 32'(out_vld), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_cur",     32'(out_cur),     32'(e.cur));
            check("out_prev",    32'(out_prev),    32'(e.prev));
            check("out_col",     32'(out_col),     32'(e.col));
            check("out_line",    32'(out_line),    32'(e.line));
            check("line_done",   32'(line_done),   32'(e.done));
            check("ram_wr_en",   32'(ram_wr_en),   32'd1);
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(e.col));
            check("ram_wr_data", 32'(ram_wr_data), 32'(e.cur));
         end
      end else begin
         check("idle_wr_en",     32'(ram_wr_en), 32'd0);
         check("idle_line_done", 32'(line_done), 32'd0);
      end
   end

   // Issue one pixel and queue its expected output pair
   task automatic pix(input logic s, input logic [DW-1:0] d, input logic [DW-1:0] prev,
                      input logic [AW-1:0] col, input logic [LW-1:0] line, input logic done);
      exp_t e;
      e.cur = d; e.prev = prev; e.col = col; e.line = line; e.done = done;
      exp_q.push_back(e);
      sof = s; pix_vld = 1'b1; pix_data = d;
      #1;
      check("ram_rd_addr", 32'(ram_rd_addr), 32'(col));
      @(posedge wr_clk); #1;
      sof = 1'b0; pix_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge wr_clk); #1;
      end
   endtask

   task automatic check_reset_state();
      check("rst_wr_en",   32'(ram_wr_en),   32'd0);
      check("rst_out_vld", 32'(out_vld),     32'd0);
      check("rst_done",    32'(line_done),   32'd0);
      check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
      check("rst_wr_data", 32'(ram_wr_data), 32'd0);
      check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
      check("rst_cur",     32'(out_cur),     32'd0);
      check("rst_prev",    32'(out_prev),    32'd0);
      check("rst_col",     32'(out_col),     32'd0);
      check("rst_line",    32'(out_line),    32'd0);
      check("rst_state",   32'(dut.state_r), 32'(ST_IDLE));
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
      tb_wr_rst = 1'b1; sof = 1'b0; pix_vld = 1'b0; pix_data = 8'h00;
      idle(3);
      check_reset_state();
      tb_wr_rst = 1'b0;
      idle(1);

      // pix_vld without sof is ignored
      for (int i = 0; i < 3; i++) begin
         pix_vld = 1'b1; pix_data = 8'hA0 + 8'(i);
         @(posedge wr_clk); #1;
      end
      pix_vld = 1'b0;
      check("noSof_state", 32'(dut.state_r), 32'(ST_IDLE));
      check("noSof_wr_en", 32'(ram_wr_en), 32'd0);
      idle(2);

      // Line 0: previous line masked
      for (int i = 0; i < 4; i++)
         pix(i == 0, 8'h10 + 8'(i), 8'h00, 11'(i), 12'd0, i == 3);
      check("line0_state", 32'(dut.state_r), 32'(ST_LINEN));
      // Line 1: previous line returned from RAM
      for (int i = 0; i < 4; i++)
         pix(1'b0, 8'h20 + 8'(i), 8'h10 + 8'(i), 11'(i), 12'd1, i == 3);
      // Line 2 with 2-cycle gaps between pixels
      for (int i = 0; i < 4; i++) begin
         pix(1'b0, 8'h30 + 8'(i), 8'h20 + 8'(i), 11'(i), 12'd2, i == 3);
         idle(2);
      end
      // Line 3 cut short by sof at column 2
      pix(1'b0, 8'h40, 8'h30, 11'd0, 12'd3, 1'b0);
      pix(1'b0, 8'h41, 8'h31, 11'd1, 12'd3, 1'b0);
      pix(1'b1, 8'h50, 8'h00, 11'd0, 12'd0, 1'b0);
      for (int i = 1; i < 4; i++)
         pix(1'b0, 8'h50 + 8'(i), 8'h00, 11'(i), 12'd0, i == 3);
      for (int i = 0; i < 4; i++)
         pix(1'b0, 8'h60 + 8'(i), 8'h50 + 8'(i), 11'(i), 12'd1, i == 3);
      check("restart_mem1", 32'(mem[1]), 32'h61);

      // Reset mid-line drops the pending output
      pix(1'b0, 8'h70, 8'h60, 11'd0, 12'd2, 1'b0);
      pix(1'b0, 8'h71, 8'h61, 11'd1, 12'd2, 1'b0);
      tb_wr_rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_state();
      idle(3);
      check_reset_state();
      tb_wr_rst = 1'b0;
      idle(1);

      // Fresh frame over stale RAM contents
      for (int i = 0; i < 4; i++)
         pix(i == 0, 8'h80 + 8'(i), 8'h00, 11'(i), 12'd0, i == 3);
      for (int i = 0; i < 4; i++)
         pix(1'b0, 8'h90 + 8'(i), 8'h80 + 8'(i), 11'(i), 12'd1, i == 3);

      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sdpram_line_buf_ctrl

// File: doc/sdpram_line_buf_ctrl.md
Name: sdpram_line_buf_ctrl

Overview:
- Single-clock sequencer that drives the 2048x8 simple dual-port RAM (blk_mem_gen_0) as a one-line delay buffer for the binarization/morphology pipeline.
- Writes each incoming pixel at its column address and reads the previous line's pixel from the same column.
- Presents current and previous-line pixels together, aligned, one cycle later.
- Tracks frame/line position with a small state machine; both RAM ports are clocked from wr_clk.

Parameters:
- ADDR_WIDTH, 11, RAM address width; column counter width.
- DATA_WIDTH, 8, pixel/RAM data width.
- LINE_LEN, 1280, active pixels per line; legal range 2..2**ADDR_WIDTH (elaboration-time check, fatal if violated).
- LINE_CNT_W, 12, line counter width.

Ports:
- wr_clk  in  1  clock for controller and both RAM ports.
- tb_wr_rst  in  1  reset, asynchronous, active-high.
- sof  in  1  start-of-frame pulse, qualified with pix_vld.
- pix_vld  in  1  input pixel valid.
- pix_data  in  DATA_WIDTH  input pixel.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address (RAM read latency 1, no output register).
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- out_vld  out  1  output pixel pair valid.
- out_cur  out  DATA_WIDTH  current-line pixel.
- out_prev  out  DATA_WIDTH  same-column pixel of previous line; 0 on line 0.
- out_col  out  ADDR_WIDTH  column of the output pair.
- out_line  out  LINE_CNT_W  line index of the output pair.
- line_done  out  1  one-cycle pulse with the last pixel of a line.

Behaviour:
- Reset values:
  - state = IDLE; col = 0; line_cnt = 0.
  - ram_wr_en, out_vld, line_done = 0.
  - All address and data outputs = 0.
- States:
  - IDLE: pix_vld without sof is ignored.
  - LINE0: first line of the frame.
  - LINEN: any later line.
- Transitions:
  - Any state, sof & pix_vld -> LINE0; the pixel is column 0 of line 0 (col restarts mid-line if necessary).
  - LINE0, accepted pixel with col == LINE_LEN-1 -> LINEN.
  - LINEN stays in LINEN until the next sof.
- Accept stage (cycle N, pixel accepted when pix_vld and state != IDLE, or sof & pix_vld):
  - ram_rd_addr = effective column (0 if sof, else col), combinational from registered col.
  - col: next = effective column + 1; wraps to 0 after LINE_LEN-1.
  - On wrap, line_cnt increments and saturates at all-ones.
- Write/output stage (cycle N+1, registered):
  - ram_wr_en = 1; ram_wr_addr = column of N; ram_wr_data = pixel of N.
  - out_vld = 1; out_cur = pixel of N; out_col, out_line = position of N.
  - out_prev = ram_rd_data when the pixel was in LINEN, 0 when it was in LINE0.
  - line_done = 1 when column of N == LINE_LEN-1.
- Latency: exactly 1 cycle from accept to out_vld.
- Read-before-write: the old value is read at N and overwritten at N+1.
  - Back-to-back pixels give wr addr c and rd addr c+1 in the same cycle, so there is never a same-address collision (LINE_LEN >= 2).
- Gaps (pix_vld = 0): col and state hold; ram_wr_en and out_vld deassert next cycle.
- Reset mid-line: everything returns to reset values immediately; any pending write is dropped; RAM contents are not cleared. The next frame's LINE0 masks the stale data.
- sof arriving while the previous pixel's write is pending: that write still completes in the same cycle as the new accept.

Decomposition:
- Shared package line_buf_pkg holds:
  - state enum {IDLE, LINE0, LINEN};
  - default constants ADDR_WIDTH = 11, DATA_WIDTH = 8, LINE_LEN = 1280.
- No sub-module: the controller is flat.
- Integration wrapper sdpram_line_buf instantiates sdpram_line_buf_ctrl plus blk_mem_gen_0, with wr_clk tied to both RAM clocks and tb_wr_rst to both RAM resets.

Test Plan:
- Reset, then pix_vld pulses without sof -> ram_wr_en = 0, out_vld = 0, state stays IDLE.
- LINE_LEN = 4, sof + 4 pixels 0x10..0x13 -> writes at addr 0..3; out_prev = 0 for all; line_done on 0x13 at out_col = 3; state LINEN.
- Continue with pixels 0x20..0x23 -> out_prev = 0x10..0x13, out_line = 1, addr wraps 3->0.
- Pixels with 2-cycle pix_vld gaps mid-line -> same out_prev pairing; col holds during gaps; no spurious out_vld.
- sof at col 2 of line 3 -> new pixel at out_col = 0, out_line = 0, out_prev = 0; the pending write of the previous pixel still occurs.
- Assert tb_wr_rst mid-line for 3 cycles -> all outputs 0 immediately. A new sof frame then restarts cleanly at col 0, line 0, with out_prev = 0 throughout line 0.
